booth_r4_mult: RTL and testbench

Parametrised radix-4 Booth sequential multiplier, the next generation of the team's radix-2 Booth multiplier. Retires two multiplier bits per cycle with a fixed, operand-independent latency. Supports signed and unsigned operands, selected per operation, and uses an explicit start/busy/done handshake. Sits behind datapath control logic that issues one multiply at a time and consumes a registered product.

---
 rtl/booth_r4_mult.sv | 134 +++++++++++++
 tb/tb_booth_r4_mult.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_mult.sv
// Radix-4 Booth sequential multiplier with a fixed latency of N_ITER+1 cycles.
// Retires two multiplier bits per cycle. The operands are treated as signed or
// unsigned, as chosen for each operation.
// Ports:
//   clk, rst_n          - clock (rising edge) and synchronous active-low reset
//   start               - request a multiply; accepted only while busy=0
//   signed_mode         - 1: two's complement operands, 0: unsigned
//   a, b                - multiplicand and multiplier, sampled with start
//   busy                - operation in progress
//   done                - one-cycle pulse when product is updated
//   product             - registered 2*WIDTH result, held until the next done
module booth_r4_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned N_ITER = WIDTH / 2 + 1;
  localparam int unsigned AW     = 2 * WIDTH + 2;   // accumulator / A-term width
  localparam int unsigned MW     = WIDTH + 3;       // extended multiplier plus bit -1
  localparam int unsigned CW     = $clog2(N_ITER + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      mcand_q, mcand_d;
  logic [MW-1:0]      mplier_q, mplier_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [CW-1:0]      iter_q, iter_d;
  logic               busy_d, done_d;
  logic [2*WIDTH-1:0] product_d;

  logic [AW-1:0]      booth_term;
  logic [AW-1:0]      acc_sum;
  logic               last_iter;

  assign last_iter = (iter_q == CW'(N_ITER - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      iter_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      iter_q   <= iter_d;
      busy     <= busy_d;
      done     <= done_d;
      product  <= product_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last_iter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Booth recoding of the current multiplier triple {m[2i+1], m[2i], m[2i-1]}
  always_comb begin
    booth_term = '0;
    case (mplier_q[2:0])
      3'b001, 3'b010: booth_term = mcand_q;
      3'b011:         booth_term = mcand_q << 1;
      3'b100:         booth_term = -(mcand_q << 1);
      3'b101, 3'b110: booth_term = -mcand_q;
      default:        booth_term = '0;
    endcase
  end

  assign acc_sum = acc_q + booth_term;

  // Datapath and output next values
  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    iter_d    = iter_q;
    busy_d    = busy;
    done_d    = 1'b0;
    product_d = product;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Extend by signed_mode: replicate the MSB only for signed operands
          mcand_d  = {{(AW - WIDTH){signed_mode & a[WIDTH-1]}}, a};
          mplier_d = {{2{signed_mode & b[WIDTH-1]}}, b, 1'b0};
          acc_d    = '0;
          iter_d   = '0;
          busy_d   = 1'b1;
        end
      end
      CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 2;
        mplier_d = {{2{mplier_q[MW-1]}}, mplier_q[MW-1:2]};
        iter_d   = iter_q + CW'(1);
        if (last_iter) begin
          product_d = acc_sum[2*WIDTH-1:0];
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_r4_mult.sv
module tb_booth_r4_mult;

  logic clk;
  logic rst_n;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  logic        start16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;

  int checks;
  int errors;

  booth_r4_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
  );

  booth_r4_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .product(prod16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference product: interpret operands per mode, multiply, keep 2*w bits
  function automatic logic [63:0] ref_mul(input int w, input logic sm,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, mask;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    p    = sa * sb;
    mask = (longint'(1) << (2 * w)) - 1;
    return 64'(p & mask);
  endfunction

  // Issue one operation at the current negedge; return product, latency, busy cycles
  task automatic run_op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] prod, output int lat, output int bcnt,
                         output logic busy_at_done);
    start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; sm8 = ~sm;
    lat = 1;
    bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      @(negedge clk);
      lat++;
    end
    prod = prod8;
    busy_at_done = busy8;
  endtask

  task automatic run_op16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                          output logic [31:0] prod, output int lat);
    start16 = 1'b1; sm16 = sm; a16 = a; b16 = b;
    @(negedge clk);
    start16 = 1'b0;
    a16 = ~a; b16 = ~b;
    lat = 1;
    while (!done16 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    prod = prod16;
  endtask

  initial begin
    vec_t        vecs[12];
    logic [15:0] p;
    logic [15:0] p1, p2;
    logic        bd;
    int          lat, bcnt, first, second, ndone, done_at;

    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[2]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[3]  = '{1'b1, 8'h7F, 8'hFF, 16'hFF81};
    vecs[4]  = '{1'b1, 8'h00, 8'h5A, 16'h0000};
    vecs[5]  = '{1'b0, 8'h00, 8'h00, 16'h0000};
    vecs[6]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[7]  = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vecs[8]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    vecs[9]  = '{1'b0, 8'hFF, 8'h01, 16'h00FF};
    vecs[10] = '{1'b1, 8'h80, 8'h01, 16'hFF80};
    vecs[11] = '{1'b0, 8'h7F, 8'h80, 16'h3F80};

    rst_n = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy8), 64'd0);
    check("reset_done", 64'(done8), 64'd0);
    check("reset_product", 64'(prod8), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors: product, latency, busy span, busy low on done
    for (int i = 0; i < 12; i++) begin
      run_op8(vecs[i].sm, vecs[i].a, vecs[i].b, p, lat, bcnt, bd);
      check($sformatf("vec%0d_product", i), 64'(p), 64'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd6);
      check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd5);
      check($sformatf("vec%0d_busy_at_done", i), 64'(bd), 64'd0);
    end
    @(negedge clk);

    // Back-to-back with start held high; second op issued in the first done cycle
    start8 = 1'b1; sm8 = 1'b1; a8 = 8'd3; b8 = 8'd5;
    first = -1; second = -1; p1 = '0; p2 = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done8) begin
        if (first < 0) begin
          first = c; p1 = prod8;
          a8 = 8'hF9; b8 = 8'h06;
        end else if (second < 0) begin
          second = c; p2 = prod8;
          start8 = 1'b0;
        end
      end
    end
    start8 = 1'b0;
    check("b2b_first_latency", 64'(first), 64'd6);
    check("b2b_gap", 64'(second - first), 64'd6);
    check("b2b_product1", 64'(p1), 64'h000F);
    check("b2b_product2", 64'(p2), 64'hFFD6);

    // Start while busy is ignored
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b1; a8 = 8'h55; b8 = 8'h66;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0; done_at = -1; p = '0;
    for (int c = 3; c <= 16; c++) begin
      if (done8) begin
        ndone++;
        if (done_at < 0) begin done_at = c; p = prod8; end
      end
      @(negedge clk);
    end
    check("busy_start_done_count", 64'(ndone), 64'd1);
    check("busy_start_latency", 64'(done_at), 64'd6);
    check("busy_start_product", 64'(p), 64'h03A8);

    // Reset mid-operation aborts without a done pulse
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'h21; b8 = 8'h43;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_done", 64'(done8), 64'd0);
    check("abort_product", 64'(prod8), 64'd0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      if (done8) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    run_op8(1'b0, 8'h21, 8'h43, p, lat, bcnt, bd);
    check("after_abort_product", 64'(p), 64'h08A3);
    check("after_abort_latency", 64'(lat), 64'd6);

    // Randomised sweep on both widths in parallel
    fork
      begin
        logic [15:0] rp;
        logic        rbd;
        int          rl, rb;
        logic        s;
        logic [7:0]  ra, rbv;
        for (int i = 0; i < 5000; i++) begin
          s = 1'($urandom);
          ra = 8'($urandom);
          rbv = 8'($urandom);
          run_op8(s, ra, rbv, rp, rl, rb, rbd);
          check($sformatf("rnd8_%0d_product s=%0d a=%0h b=%0h", i, s, ra, rbv),
                64'(rp), ref_mul(8, s, 32'(ra), 32'(rbv)));
          check($sformatf("rnd8_%0d_latency", i), 64'(rl), 64'd6);
        end
      end
      begin
        logic [31:0] rp;
        int          rl;
        logic        s;
        logic [15:0] ra, rbv;
        for (int i = 0; i < 5000; i++) begin
          s = 1'($urandom);
          ra = 16'($urandom);
          rbv = 16'($urandom);
          if (i == 0) begin s = 1'b1; ra = 16'h8000; rbv = 16'h8000; end
          if (i == 1) begin s = 1'b0; ra = 16'hFFFF; rbv = 16'hFFFF; end
          run_op16(s, ra, rbv, rp, rl);
          check($sformatf("rnd16_%0d_product s=%0d a=%0h b=%0h", i, s, ra, rbv),
                64'(rp), ref_mul(16, s, 32'(ra), 32'(rbv)));
          check($sformatf("rnd16_%0d_latency", i), 64'(rl), 64'd10);
        end
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
